// File: rtl/data_sram_arbiter_if.sv
// data_sram_arbiter_if: bundle of the two requester ports and the data SRAM pins.
//   m0_* / m1_* : req, wr, wstrb[3:0], addr[31:0], wdata[31:0] (requester -> arbiter)
//                 addr_ok, data_ok, rdata[31:0]                (arbiter -> requester)
//   data_sram_* : en, wen[3:0], addr[31:0], wdata[31:0]         (arbiter -> SRAM)
//                 rdata[31:0]                                  (SRAM -> arbiter)
// slave  : arbiter side
// master : requesters plus SRAM environment side
interface data_sram_arbiter_if;
  logic        m0_req;
  logic        m0_wr;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_addr_ok;
  logic        m0_data_ok;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_wr;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_addr_ok;
  logic        m1_data_ok;
  logic [31:0] m1_rdata;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport slave (
    input  m0_req, m0_wr, m0_wstrb, m0_addr, m0_wdata,
    output m0_addr_ok, m0_data_ok, m0_rdata,
    input  m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata,
    output m1_addr_ok, m1_data_ok, m1_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport master (
    output m0_req, m0_wr, m0_wstrb, m0_addr, m0_wdata,
    input  m0_addr_ok, m0_data_ok, m0_rdata,
    output m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata,
    input  m1_addr_ok, m1_data_ok, m1_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_arbiter.sv
// data_sram_arbiter: shares one single-port synchronous data SRAM between
// requester 0 (execute-stage load/store) and requester 1 (secondary master).
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : data_sram_arbiter_if.slave (m0/m1 handshakes and data_sram_* pins)
// Parameters:
//   SRAM_LAT     (1..3)  cycles from data_sram_en to valid data_sram_rdata
//   STARVE_LIMIT (1..15) lost-arbitration cycles before m1 is force-granted
// Build option:
//   DATA_SRAM_ARB_RR_EN : replaces fixed m0 priority + starvation guard with a
//                         1-bit round-robin pointer.
module data_sram_arbiter #(
  parameter int unsigned SRAM_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                reset,
  data_sram_arbiter_if.slave bus
);

  logic                grant0;
  logic                grant1;
  logic [SRAM_LAT-1:0] vld_q, vld_d;
  logic [SRAM_LAT-1:0] id_q,  id_d;
  logic                resp_vld;
  logic                resp_id;

`ifdef DATA_SRAM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (bus.m0_req && bus.m1_req) begin
        grant1 = rr_ptr_q;
        grant0 = !rr_ptr_q;
      end else begin
        grant0 = bus.m0_req;
        grant1 = bus.m1_req;
      end
    end
  end

  // Pointer always ends up on the requester that was not granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant1) begin
      rr_ptr_d = 1'b0;
    end else if (grant0) begin
      rr_ptr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       starved;

  always_comb begin
    starved = bus.m1_req && (starve_cnt_q >= 4'(STARVE_LIMIT));
    grant1  = !reset && bus.m1_req && (starved || !bus.m0_req);
    grant0  = !reset && bus.m0_req && !grant1;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.m1_req || grant1) begin
      starve_cnt_d = '0;
    end else if (grant0 && (starve_cnt_q != 4'hf)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // SRAM drive from the granted requester, all-zero when idle.
  always_comb begin
    bus.data_sram_en    = grant0 | grant1;
    bus.data_sram_wen   = '0;
    bus.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;
    if (grant0) begin
      bus.data_sram_wen   = bus.m0_wr ? bus.m0_wstrb : 4'h0;
      bus.data_sram_addr  = bus.m0_addr;
      bus.data_sram_wdata = bus.m0_wdata;
    end else if (grant1) begin
      bus.data_sram_wen   = bus.m1_wr ? bus.m1_wstrb : 4'h0;
      bus.data_sram_addr  = bus.m1_addr;
      bus.data_sram_wdata = bus.m1_wdata;
    end
  end

  // Response tracker: {valid, id} shifted in lockstep with the SRAM latency.
  if (SRAM_LAT > 1) begin : g_shift
    always_comb begin
      vld_d = {vld_q[SRAM_LAT-2:0], grant0 | grant1};
      id_d  = {id_q[SRAM_LAT-2:0], grant1};
    end
  end else begin : g_single
    always_comb begin
      vld_d = grant0 | grant1;
      id_d  = grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  always_comb begin
    resp_vld       = vld_q[SRAM_LAT-1] && !reset;
    resp_id        = id_q[SRAM_LAT-1];
    bus.m0_addr_ok = bus.m0_req & grant0;
    bus.m1_addr_ok = bus.m1_req & grant1;
    bus.m0_data_ok = 1'b0;
    bus.m1_data_ok = 1'b0;
    bus.m0_rdata   = '0;
    bus.m1_rdata   = '0;
    if (resp_vld) begin
      if (resp_id) begin
        bus.m1_data_ok = 1'b1;
        bus.m1_rdata   = bus.data_sram_rdata;
      end else begin
        bus.m0_data_ok = 1'b1;
        bus.m0_rdata   = bus.data_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_arbiter.sv
// tb_data_sram_arbiter: directed + random stimulus for data_sram_arbiter with
// a behavioural SRAM of latency LAT and an in-order response scoreboard.
module tb_data_sram_arbiter;
  localparam int unsigned LAT    = 3;
  localparam int unsigned STARVE = 4;
`ifdef DATA_SRAM_ARB_RR_EN
  localparam logic [9:0] EXP_HIST = 10'b10_1010_1010;
`else
  localparam logic [9:0] EXP_HIST = 10'b10_0001_0000;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_sram_arbiter_if bus ();

  data_sram_arbiter #(.SRAM_LAT(LAT), .STARVE_LIMIT(STARVE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction

  // Behavioural SRAM: read returns the pre-write word, LAT cycles after en.
  logic [31:0] mem  [int];
  logic [31:0] gold [int];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk) begin : sram_model
    int          k;
    logic [31:0] old;
    k   = int'(bus.data_sram_addr[31:2]);
    old = mem.exists(k) ? mem[k] : 32'h0;
    if (bus.data_sram_en) mem[k] = merge(old, bus.data_sram_wdata, bus.data_sram_wen);
    rd_pipe[0] <= bus.data_sram_en ? old : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.data_sram_rdata = rd_pipe[LAT-1];

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t       sb[$];
  int         cyc     = 0;
  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] starve_m = '0;
  logic       ptr_m    = 1'b0;
  logic [9:0] hist     = '0;
  int         hidx     = 0;
  bit         hist_on  = 1'b0;
  logic       acc0     = 1'b0;
  logic       acc1     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
  endtask

  task automatic set_m0(input bit req, input bit wr, input logic [3:0] strb,
                        input logic [31:0] a, input logic [31:0] d);
    bus.m0_req = req; bus.m0_wr = wr; bus.m0_wstrb = strb; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input bit req, input bit wr, input logic [3:0] strb,
                        input logic [31:0] a, input logic [31:0] d);
    bus.m1_req = req; bus.m1_wr = wr; bus.m1_wstrb = strb; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  // Checks one cycle at the falling edge, advances the model, returns at posedge+1.
  task automatic tick();
    bit          g0, g1;
    logic [31:0] ea, ewd;
    logic [3:0]  ewen;
    rsp_t        r;
    int          k;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
`ifdef DATA_SRAM_ARB_RR_EN
      if (bus.m0_req && bus.m1_req) begin
        g1 = ptr_m;
        g0 = !ptr_m;
      end else begin
        g0 = bus.m0_req;
        g1 = bus.m1_req;
      end
`else
      if (bus.m1_req && ((starve_m >= STARVE) || !bus.m0_req)) g1 = 1'b1;
      else g0 = bus.m0_req;
`endif
    end
    ea = '0; ewd = '0; ewen = '0;
    if (g0) begin
      ea = bus.m0_addr; ewd = bus.m0_wdata; ewen = bus.m0_wr ? bus.m0_wstrb : 4'h0;
    end else if (g1) begin
      ea = bus.m1_addr; ewd = bus.m1_wdata; ewen = bus.m1_wr ? bus.m1_wstrb : 4'h0;
    end
    chk("m0_addr_ok", bus.m0_addr_ok, g0);
    chk("m1_addr_ok", bus.m1_addr_ok, g1);
    chk("sram_en", bus.data_sram_en, g0 | g1);
    chk("sram_wen", bus.data_sram_wen, ewen);
    chk("sram_addr", bus.data_sram_addr, ea);
    chk("sram_wdata", bus.data_sram_wdata, ewd);

    if (!reset && sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk("m0_data_ok", bus.m0_data_ok, !r.id);
      chk("m1_data_ok", bus.m1_data_ok, r.id);
      chk("m0_rdata", bus.m0_rdata, r.id ? 32'h0 : r.data);
      chk("m1_rdata", bus.m1_rdata, r.id ? r.data : 32'h0);
    end else begin
      chk("m0_data_ok_idle", bus.m0_data_ok, 1'b0);
      chk("m1_data_ok_idle", bus.m1_data_ok, 1'b0);
      chk("m0_rdata_idle", bus.m0_rdata, 32'h0);
      chk("m1_rdata_idle", bus.m1_rdata, 32'h0);
    end
    if (reset) sb.delete();

    if (g0 || g1) begin
      k      = int'(ea[31:2]);
      r.id   = g1;
      r.data = gold.exists(k) ? gold[k] : 32'h0;
      r.due  = cyc + int'(LAT);
      sb.push_back(r);
      if (ewen != 4'h0) gold[k] = merge(r.data, ewd, ewen);
    end

    acc0 = bus.m0_addr_ok;
    acc1 = bus.m1_addr_ok;
    if (hist_on && hidx < 10) begin
      hist[hidx] = bus.m1_addr_ok;
      hidx++;
    end

    if (reset || !bus.m1_req || g1) starve_m = '0;
    else if (g0 && starve_m != 4'hf) starve_m = starve_m + 4'd1;
    if (reset || g1) ptr_m = 1'b0;
    else if (g0) ptr_m = 1'b1;

    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a0, a1;
    for (int a = 'h100; a < 'h140; a += 4) begin
      mem[a >> 2]  = {16'hC0DE, a[15:0]};
      gold[a >> 2] = {16'hC0DE, a[15:0]};
    end
    mem['h100 >> 2]  = 32'hDEADBEEF;
    gold['h100 >> 2] = 32'hDEADBEEF;
    mem['h200 >> 2]  = 32'hAABBCCDD;
    gold['h200 >> 2] = 32'hAABBCCDD;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;

    // Reset with m0 already requesting: grants must stay off until release.
    reset = 1'b1;
    set_m0(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    reset = 1'b0;

    // Single read of 0x100.
    tick();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (LAT + 1) tick();

    // m1 partial write then read-back of 0x200.
    set_m1(1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678);
    tick();
    set_m1(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    tick();
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (LAT + 1) tick();

    // Back-to-back m0 / m1 / m0 reads.
    set_m0(1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
    tick();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, 32'h108, 32'h0);
    tick();
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m0(1'b1, 1'b0, 4'h0, 32'h10C, 32'h0);
    tick();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (LAT + 1) tick();

    // Reset one cycle after an accepted read: the response must vanish.
    set_m0(1'b1, 1'b0, 4'h0, 32'h110, 32'h0);
    tick();
    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (LAT + 2) tick();

    // Fresh reset, then continuous contention from both requesters.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a0 = 32'h100;
    a1 = 32'h120;
    hist_on = 1'b1;
    hidx    = 0;
    set_m0(1'b1, 1'b0, 4'h0, a0, 32'h0);
    set_m1(1'b1, 1'b0, 4'h0, a1, 32'h0);
    repeat (10) begin
      tick();
      if (acc0) a0 = a0 + 32'h4;
      if (acc1) a1 = a1 + 32'h4;
      set_m0(1'b1, 1'b0, 4'h0, a0, 32'h0);
      set_m1(1'b1, 1'b0, 4'h0, a1, 32'h0);
    end
    hist_on = 1'b0;
    chk("grant_pattern", {22'h0, hist}, {22'h0, EXP_HIST});

    // Random traffic; payload only changes once the current one is accepted.
    repeat (40) begin
      if (!bus.m0_req || acc0)
        set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
               32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom);
      if (!bus.m1_req || acc1)
        set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
               32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom);
      tick();
    end

    set_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (LAT + 2) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_sram_arbiter.md
Name: data_sram_arbiter

Overview:
- Shares the single-port synchronous data SRAM between two requesters.
- Requester 0 is the pipeline's execute-stage load/store port. Requester 1 is a secondary master, such as a store-buffer drain or debug access.
- Handles grant selection, a per-request addr_ok/data_ok handshake, and in-order return of SRAM read data, with latency set by parameter.
- Sits between the execute/memory stages and the data_sram_* pins.

Parameters:
- SRAM_LAT, 1: cycles from SRAM enable to read data valid. Legal values are 1..3.
- STARVE_LIMIT, 4: number of consecutive cycles requester 1 may lose arbitration before it is force-granted. Legal values are 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- m0_req  in  1  requester 0 request valid
- m0_wr  in  1  1 = write, 0 = read
- m0_wstrb  in  4  byte write strobes, ignored when m0_wr = 0
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_addr_ok  out  1  request 0 accepted this cycle
- m0_data_ok  out  1  response for an accepted m0 request
- m0_rdata  out  32  read data, valid when m0_data_ok is high
- m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata  in  1/1/4/32/32  requester 1, same meaning as the m0 signals
- m1_addr_ok, m1_data_ok  out  1  same meaning as the m0 signals
- m1_rdata  out  32  same meaning as m0_rdata
- data_sram_en  out  1  SRAM enable
- data_sram_wen  out  4  SRAM byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- data_sram_rdata  in  32  SRAM read data, valid SRAM_LAT cycles after data_sram_en

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high. All state changes on the rising edge of clk.
- Grant rule: at most one grant per cycle, and grant is combinational from the current-cycle inputs.
  - Default: m0 has priority.
  - starve_cnt (4 bits) increments each cycle in which m1_req = 1 and m0 is granted, saturating at 15.
  - starve_cnt clears when m1 is granted or when m1_req = 0.
  - When starve_cnt >= STARVE_LIMIT and m1_req = 1, m1 wins over m0.
- Address handshake: mX_addr_ok = mX_req & grantX, in the same cycle.
  - A requester must hold its req and payload stable until its addr_ok is seen.
  - A request is transferred on a cycle where req & addr_ok are both high.
- SRAM drive (combinational from the granted requester):
  - data_sram_en = grant0 | grant1.
  - data_sram_wen = wr ? wstrb : 4'h0.
  - data_sram_addr and data_sram_wdata are taken from the granted requester.
  - With no grant: en = 0, wen = 0, addr = 0, wdata = 0.
- Response pipeline: a shift register of depth SRAM_LAT. Each entry holds {valid, id}.
  - Stage 0 is loaded with {grant0 | grant1, grant1} at every edge.
  - At the last stage, when valid = 1:
    - m{id}_data_ok = 1.
    - m{id}_rdata = data_sram_rdata.
    - The other requester's data_ok = 0.
  - Writes also return data_ok at the same latency. rdata is don't-care for writes but is driven as data_sram_rdata.
  - Responses return in grant order. No backpressure exists on data_ok, so requesters must always accept a response.
  - Back-to-back grants are allowed every cycle: throughput is 1 request/cycle.
- Simultaneous events:
  - m0_req and m1_req in the same cycle follow the grant rule.
  - Requests may be accepted while earlier responses are still in flight.
- Reset values:
  - All shift-register valid bits = 0.
  - starve_cnt = 0.
  - All *_data_ok = 0.
  - rdata outputs = 0 while their data_ok = 0.
- Reset mid-operation: in-flight responses are discarded, and no data_ok is issued for requests accepted before reset. While reset is high, addr_ok and data_sram_en are forced to 0.

Optional Feature:
- DATA_SRAM_ARB_RR_EN, when defined: the grant rule is replaced by a 1-bit round-robin pointer.
  - Reset value of the pointer is 0, meaning m0 is preferred.
  - When both requesters request, the pointer-preferred one wins.
  - After any grant, the pointer points to the non-granted requester.
  - A single requester is always granted.
  - starve_cnt and STARVE_LIMIT are unused.
- When not defined: fixed m0 priority with the starvation guard described above.

Test Plan:
- Single read: SRAM_LAT = 1; m0 reads 0x100, where the SRAM holds 0xDEADBEEF → m0_addr_ok in cycle 0, data_sram_wen = 0; m0_data_ok with m0_rdata = 0xDEADBEEF in cycle 1; m1_data_ok stays 0.
- Write then read: m1 writes 0x200 with wdata 0x12345678 and wstrb 4'b0011; next cycle m1 reads 0x200 → data_sram_wen = 4'b0011 on the write; two m1_data_ok pulses in order; read returns 0x????5678, with the upper bytes holding their prior contents.
- Contention: m0 and m1 both request continuously with STARVE_LIMIT = 4, macro undefined → m0 granted for 4 cycles, m1 granted in the 5th, then m0 again; the pattern repeats every 5 cycles.
- Round-robin: DATA_SRAM_ARB_RR_EN defined; both requesters request continuously → grants alternate m0, m1, m0, m1, starting with m0 after reset.
- Latency: SRAM_LAT = 3; m0 reads A, m1 reads B, m0 reads C on consecutive cycles → m0_data_ok, m1_data_ok, m0_data_ok on cycles 3, 4, 5, each with matching rdata.
- Reset in flight: SRAM_LAT = 2; m0 read accepted at cycle 0, reset asserted at cycle 1 → no data_ok at cycle 2; all outputs are 0 during reset.
